// File: rtl/vga_fetch_scheduler.sv
`timescale 1ns/1ps
// vga_fetch_scheduler: line-prefetch sequencer and framebuffer-port arbiter for the VGA pixel path
// Ports: vga_clk/reset_n pixel clock and async active-low reset; vga_start, column_counter,
// row_counter from the sync generator; fb_base framebuffer byte base (latched at vblank start);
// mem_* shared framebuffer port (one transaction outstanding); lb_* ping-pong line-buffer
// write port; disp_bank bank read by the pixel path; host_* single-word CPU port;
// underrun pulses when the next line is still being fetched at bank swap.
module vga_fetch_scheduler #(
    parameter int H_DISPLAY      = 640,
    parameter int H_TOTAL        = 800,
    parameter int V_DISPLAY      = 480,
    parameter int V_TOTAL        = 525,
    parameter int WORDS_PER_LINE = 320,
    parameter int BURST_LEN      = 16,
    parameter int ADDR_W         = 32
) (
    input  logic              vga_clk,
    input  logic              reset_n,
    input  logic              vga_start,
    input  logic [10:0]       column_counter,
    input  logic [9:0]        row_counter,
    input  logic [ADDR_W-1:0] fb_base,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [7:0]        mem_len,
    output logic [31:0]       mem_wdata,
    input  logic              mem_ack,
    input  logic              mem_rvalid,
    input  logic [31:0]       mem_rdata,
    output logic              lb_we,
    output logic              lb_bank,
    output logic [8:0]        lb_addr,
    output logic [31:0]       lb_wdata,
    output logic              disp_bank,
    input  logic              host_req,
    input  logic              host_we,
    input  logic [ADDR_W-1:0] host_addr,
    input  logic [31:0]       host_wdata,
    output logic              host_ack,
    output logic              host_rvalid,
    output logic [31:0]       host_rdata,
    output logic              underrun
);
    localparam logic [2:0] IDLE = 3'd0, F_REQ = 3'd1, F_DATA = 3'd2, H_REQ = 3'd3, H_RD = 3'd4;
    logic [2:0]        state;
    logic              fetch_pending, abort, host_turn, fill_bank;
    logic [ADDR_W-1:0] fb_base_lat, fetch_addr;
    logic [9:0]        target;
    logic [8:0]        word_idx;
    logic [7:0]        beat;
    logic              row_ok, trigger, swap, abort_now, in_fetch, fetch_go;
    assign row_ok     = (row_counter < 10'(V_DISPLAY - 1)) || (row_counter == 10'(V_TOTAL - 1));
    assign trigger    = vga_start && column_counter == 11'(H_DISPLAY) && row_ok && !fetch_pending;
    assign swap       = column_counter == 11'(H_TOTAL - 1) && row_ok;
    assign in_fetch   = state == F_REQ || state == F_DATA;
    // a swap landing on the final beat must still retire the line, otherwise it would stay pending
    assign abort_now  = abort || (swap && fetch_pending);
    // a swap that kills the line in IDLE must not also start a burst on the same edge
    assign fetch_go   = fetch_pending && !abort && !swap && !(host_req && host_turn);
    assign fetch_addr = fb_base_lat + ((ADDR_W'(target) * ADDR_W'(WORDS_PER_LINE) + ADDR_W'(word_idx)) << 2);
    assign host_ack   = state == H_REQ && mem_req && mem_ack;
    always_ff @(posedge vga_clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
            fetch_pending <= 1'b0;
            abort <= 1'b0;
            host_turn <= 1'b0;
            fill_bank <= 1'b0;
            fb_base_lat <= '0;
            target <= '0;
            word_idx <= '0;
            beat <= '0;
            mem_req <= 1'b0;
            mem_we <= 1'b0;
            mem_addr <= '0;
            mem_len <= '0;
            mem_wdata <= '0;
            lb_we <= 1'b0;
            lb_bank <= 1'b0;
            lb_addr <= '0;
            lb_wdata <= '0;
            disp_bank <= 1'b0;
            host_rvalid <= 1'b0;
            host_rdata <= '0;
            underrun <= 1'b0;
        end else begin
            lb_we <= 1'b0;
            host_rvalid <= 1'b0;
            underrun <= 1'b0;
            if (column_counter == 11'd0 && row_counter == 10'(V_DISPLAY))
                fb_base_lat <= fb_base;
            if (trigger) begin
                fetch_pending <= 1'b1;
                word_idx <= '0;
                fill_bank <= ~disp_bank;
                target <= (row_counter == 10'(V_TOTAL - 1)) ? 10'd0 : row_counter + 10'd1;
            end
            if (swap) begin
                disp_bank <= ~disp_bank;
                if (fetch_pending) begin
                    underrun <= 1'b1;
                    if (in_fetch)
                        abort <= 1'b1;
                    else
                        fetch_pending <= 1'b0;
                end
            end
            case (state)
                IDLE: state <= fetch_go ? F_REQ : host_req ? H_REQ : IDLE;
                F_REQ:
                    if (!mem_req) begin
                        mem_req <= 1'b1;
                        mem_we <= 1'b0;
                        mem_addr <= fetch_addr;
                        mem_len <= 8'(BURST_LEN);
                    end else if (mem_ack) begin
                        mem_req <= 1'b0;
                        beat <= '0;
                        state <= F_DATA;
                    end
                F_DATA:
                    if (mem_rvalid) begin
                        lb_we <= 1'b1;
                        lb_bank <= fill_bank;
                        lb_addr <= word_idx;
                        lb_wdata <= mem_rdata;
                        word_idx <= word_idx + 9'd1;
                        beat <= beat + 8'd1;
                        if (beat == 8'(BURST_LEN - 1)) begin
                            host_turn <= host_req;
                            state <= IDLE;
                            if (abort_now || word_idx == 9'(WORDS_PER_LINE - 1)) begin
                                fetch_pending <= 1'b0;
                                abort <= 1'b0;
                            end
                        end
                    end
                H_REQ:
                    if (!mem_req) begin
                        mem_req <= 1'b1;
                        mem_we <= host_we;
                        mem_addr <= host_addr;
                        mem_len <= 8'd1;
                        mem_wdata <= host_wdata;
                    end else if (mem_ack) begin
                        mem_req <= 1'b0;
                        mem_we <= 1'b0;
                        state <= mem_we ? IDLE : H_RD;
                        if (mem_we)
                            host_turn <= 1'b0;
                    end
                H_RD:
                    if (mem_rvalid) begin
                        host_rdata <= mem_rdata;
                        host_rvalid <= 1'b1;
                        host_turn <= 1'b0;
                        state <= IDLE;
                    end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
